// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX stage and the Hi/Lo multiply/divide unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, Flush,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, Flush,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural Hi/Lo pair.
// Multiplies retire STEP multiplier bits per cycle over operand magnitudes,
// divides use a 1-bit/cycle restoring loop; signs are fixed up in FIX and
// Hi/Lo are written only at the edge that ends FIX.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  hilo_muldiv_if.slave bus
);

  localparam int MUL_CYC = WIDTH / STEP;
  localparam int DIV_CYC = WIDTH;
  localparam int CNT_W   = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MSUB  = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           opReg;
  logic [WIDTH-1:0]     hiReg, loReg;
  logic                 busyReg, doneReg, dbzReg;
  logic [2*WIDTH-1:0]   acc, mcandSh;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     bMag, rem, quo, aRaw;
  logic                 negRes, negRem, bZero;

  logic                 sgnIn;
  logic [WIDTH-1:0]     aMagIn, bMagIn;
  logic [WIDTH:0]       divShift, divTrial;
  logic [2*WIDTH-1:0]   prodSigned, mulRes;
  logic [WIDTH-1:0]     quoFix, remFix;

  // Two's-complement magnitude; the most-negative value maps to itself,
  // which is still its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Multiplicand times one STEP-bit multiplier digit.
  function automatic logic [2*WIDTH-1:0] partialSum(input logic [2*WIDTH-1:0] mc,
                                                    input logic [STEP-1:0] digit);
    logic [2*WIDTH-1:0] sum;
    sum = '0;
    for (int i = 0; i < STEP; i++)
      if (digit[i]) sum = sum + (mc << i);
    return sum;
  endfunction

  assign bus.Hi        = hiReg;
  assign bus.Lo        = loReg;
  assign bus.Busy      = busyReg;
  assign bus.Done      = doneReg;
  assign bus.DivByZero = dbzReg;

  // Operand decode at acceptance: signedness and magnitudes.
  always_comb begin
    sgnIn  = !(bus.Op == OP_MULTU || bus.Op == OP_DIVU);
    aMagIn = magnitude(bus.A, sgnIn);
    bMagIn = magnitude(bus.B, sgnIn);
  end

  // One restoring-division step: shift in next dividend bit, trial subtract.
  always_comb begin
    divShift = {rem, quo[WIDTH-1]};
    divTrial = divShift - {1'b0, bMag};
  end

  // Sign correction and accumulation seen by the commit edge.
  always_comb begin
    prodSigned = negRes ? (~acc + 1'b1) : acc;
    case (opReg)
      OP_MADD: mulRes = {hiReg, loReg} + prodSigned;
      OP_MSUB: mulRes = {hiReg, loReg} - prodSigned;
      default: mulRes = prodSigned;
    endcase
    quoFix = negRes ? (~quo + 1'b1) : quo;
    remFix = negRem ? (~rem + 1'b1) : rem;
    if (bZero) begin
      quoFix = '1;
      remFix = aRaw;
    end
  end

  // Control FSM, iteration datapath and Hi/Lo commit.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opReg   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      acc     <= '0;
      mcandSh <= '0;
      mplier  <= '0;
      bMag    <= '0;
      rem     <= '0;
      quo     <= '0;
      aRaw    <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      bZero   <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && !bus.Flush) begin
            opReg <= bus.Op;
            cnt   <= '0;
            case (bus.Op)
              OP_MTHI: begin
                hiReg   <= bus.A;
                doneReg <= 1'b1;
              end
              OP_MTLO: begin
                loReg   <= bus.A;
                doneReg <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                quo     <= aMagIn;
                rem     <= '0;
                bMag    <= bMagIn;
                aRaw    <= bus.A;
                bZero   <= (bus.B == '0);
                negRes  <= sgnIn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                negRem  <= sgnIn & bus.A[WIDTH-1];
                busyReg <= 1'b1;
                state   <= DIV;
              end
              default: begin
                acc     <= '0;
                mcandSh <= {{WIDTH{1'b0}}, aMagIn};
                mplier  <= bMagIn;
                negRes  <= sgnIn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                busyReg <= 1'b1;
                state   <= MUL;
              end
            endcase
          end
        end
        MUL: begin
          if (bus.Flush) begin
            busyReg <= 1'b0;
            state   <= IDLE;
          end else begin
            acc     <= acc + partialSum(mcandSh, mplier[STEP-1:0]);
            mcandSh <= mcandSh << STEP;
            mplier  <= mplier >> STEP;
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_W'(MUL_CYC - 1)) state <= FIX;
          end
        end
        DIV: begin
          if (bus.Flush) begin
            busyReg <= 1'b0;
            state   <= IDLE;
          end else begin
            if (!divTrial[WIDTH]) begin
              rem <= divTrial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= divShift[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DIV_CYC - 1)) state <= FIX;
          end
        end
        default: begin
          busyReg <= 1'b0;
          state   <= IDLE;
          if (!bus.Flush) begin
            doneReg <= 1'b1;
            if (opReg == OP_DIV || opReg == OP_DIVU) begin
              hiReg  <= remFix;
              loReg  <= quoFix;
              dbzReg <= bZero;
            end else begin
              {hiReg, loReg} <= mulRes;
            end
          end
        end
      endcase
    end
  end

endmodule
